// File: rtl/tt_scan_ctrl.sv
// Scan sequencer for a 2^SEL_W:1 mux truth-table evaluator: steps the select code,
// samples the mux output per code, rebuilds the table and compares it with a golden pattern.
module tt_scan_ctrl #(
    parameter int SEL_W  = 3,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [(1<<SEL_W)-1:0]   expected,
    output logic [SEL_W-1:0]        mux_sel,
    input  logic                    mux_y,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [(1<<SEL_W)-1:0]   result,
    output logic [SEL_W:0]          mismatch_cnt
);

    localparam int ENTRIES = 1 << SEL_W;
    localparam int WC_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(ENTRIES - 1);
    localparam logic [WC_W-1:0]  WC_INIT  = WC_W'(SETTLE);

    logic [1:0]         state;
    logic [WC_W-1:0]    wcnt;
    logic [ENTRIES-1:0] exp_q;
    logic               sample_miss;
    logic [SEL_W:0]     cnt_next;

    // The count including the current sample lets pass be decided on the final sampling edge.
    assign sample_miss = mux_y ^ exp_q[mux_sel];
    assign cnt_next    = mismatch_cnt + {{SEL_W{1'b0}}, sample_miss};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mux_sel      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            result       <= '0;
            mismatch_cnt <= '0;
            wcnt         <= '0;
            exp_q        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= SCAN;
                        busy         <= 1'b1;
                        exp_q        <= expected;
                        mux_sel      <= '0;
                        wcnt         <= WC_INIT;
                        result       <= '0;
                        mismatch_cnt <= '0;
                        pass         <= 1'b0;
                    end
                end
                SCAN: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        result[mux_sel] <= mux_y;
                        mismatch_cnt    <= cnt_next;
                        if (mux_sel != LAST_SEL) begin
                            mux_sel <= mux_sel + 1'b1;
                            wcnt    <= WC_INIT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (cnt_next == '0);
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mux_sel <= '0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mux_sel <= '0;
                end
            endcase
        end
    end

endmodule
